nibble_serial_adder: RTL and testbench

- Multi-cycle wide adder that adds WIDTH = 4*NIBBLES bit operands one nibble per clock through a single 4-bit generate/propagate slice (g_i = a_i & b_i, p_i = a_i ^ b_i, s_i = p_i ^ c_i, c_i+1 = g_i | (p_i & c_i)).
- The carry is registered between nibbles.
- It sits upstream of the 4-bit slice, sequencing operand nibbles into it, and downstream of it, assembling the sums and carries the slice produces.
- Operands come in and results go out through valid/ready handshakes.

---
 rtl/nibble_serial_adder.sv | 206 ++++++++++++++++++++
 tb/tb_nibble_serial_adder.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder.sv
// -----------------------------------------------------------------------------
// nibble_serial_adder
//   Multi-cycle adder for WIDTH = 4*NIBBLES bit operands. One 4-bit
//   generate/propagate slice is reused once per clock. The carry between
//   nibbles is held in a 1-bit register. Operands enter and results leave
//   through valid/ready handshakes.
//
// Parameters
//   NIBBLES   number of 4-bit slices per operand (legal range 2..16)
//
// Ports
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous active-high reset
//   in_valid   in   1      operand request
//   in_ready   out  1      block can accept operands (IDLE, after reset)
//   a, b       in   WIDTH  operands (unsigned or two's complement)
//   cin        in   1      carry into nibble 0
//   out_valid  out  1      result available (registered)
//   out_ready  in   1      consumer accepts result
//   sum        out  WIDTH  a + b + cin mod 2^WIDTH (registered)
//   cout       out  1      carry out of the MSB (registered)
//   ovf        out  1      signed overflow (registered)
//   busy       out  1      high in RUN or DONE
// -----------------------------------------------------------------------------
module nibble_serial_adder #(
    parameter int NIBBLES = 4,
    localparam int WIDTH  = 4 * NIBBLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int IDX_W = $clog2(NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic [IDX_W-1:0]   idx_r;
    logic               carry_r;
    logic [WIDTH-1:0]   a_sh_r;
    logic [WIDTH-1:0]   b_sh_r;
    logic [WIDTH-1:0]   sum_r;
    logic               cout_r;
    logic               ovf_r;
    logic               out_valid_r;
    // Holds in_ready low until the first edge after reset is released.
    logic               ready_en_r;
    logic               in_ready_s;
    logic               busy_s;
    logic               accept_s;
    logic               last_s;
    logic [5:0]         slice_s;

    // 4-bit generate/propagate slice. Returns {c4, c3, s[3:0]}; c3 is the
    // carry into bit 3, needed for signed overflow on the top nibble.
    function automatic logic [5:0] slice_add(
        input logic [3:0] x,
        input logic [3:0] y,
        input logic       c0
    );
        logic [4:0] c;
        logic [3:0] s;
        c[0] = c0;
        for (int i = 0; i < 4; i++) begin
            s[i]     = (x[i] ^ y[i]) ^ c[i];
            c[i + 1] = (x[i] & y[i]) | ((x[i] ^ y[i]) & c[i]);
        end
        return {c[4], c[3], s};
    endfunction

    // Slice evaluation; the current nibble always sits at bits [3:0] of the
    // operand shift registers.
    always_comb begin
        slice_s = slice_add(a_sh_r[3:0], b_sh_r[3:0], carry_r);
    end

    // Handshake and status decode from state.
    always_comb begin
        in_ready_s = 1'b0;
        busy_s     = 1'b0;
        if (state_r == ST_IDLE) begin
            in_ready_s = ready_en_r;
        end else begin
            busy_s = 1'b1;
        end
        accept_s = in_ready_s & in_valid;
        last_s   = (idx_r == LAST_IDX);
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (out_valid_r && out_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Datapath: operand shifting, carry chain, result assembly, out_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_en_r  <= 1'b0;
            idx_r       <= '0;
            carry_r     <= 1'b0;
            a_sh_r      <= '0;
            b_sh_r      <= '0;
            sum_r       <= '0;
            cout_r      <= 1'b0;
            ovf_r       <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            ready_en_r <= 1'b1;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        a_sh_r  <= a;
                        b_sh_r  <= b;
                        carry_r <= cin;
                        idx_r   <= '0;
                        sum_r   <= '0;
                    end
                end
                ST_RUN: begin
                    a_sh_r  <= {4'b0000, a_sh_r[WIDTH-1:4]};
                    b_sh_r  <= {4'b0000, b_sh_r[WIDTH-1:4]};
                    carry_r <= slice_s[5];
                    sum_r[{idx_r, 2'b00} +: 4] <= slice_s[3:0];
                    if (last_s) begin
                        // Wrap instead of incrementing so idx never passes
                        // NIBBLES-1 for non-power-of-two builds.
                        idx_r       <= '0;
                        cout_r      <= slice_s[5];
                        ovf_r       <= slice_s[5] ^ slice_s[4];
                        out_valid_r <= 1'b1;
                    end else begin
                        idx_r <= idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_s;
    assign busy      = busy_s;
    assign out_valid = out_valid_r;
    assign sum       = sum_r;
    assign cout      = cout_r;
    assign ovf       = ovf_r;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_nibble_serial_adder
//   Directed self-checking bench. Instantiates a 4-nibble and a 2-nibble build
//   of nibble_serial_adder on a shared clock. Inputs are driven and outputs
//   sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_nibble_serial_adder;

    logic        clk;
    logic        rst;

    // 4-nibble instance
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        busy;

    // 2-nibble instance
    logic        in_valid2;
    logic        in_ready2;
    logic [7:0]  a2;
    logic [7:0]  b2;
    logic        cin2;
    logic        out_valid2;
    logic        out_ready2;
    logic [7:0]  sum2;
    logic        cout2;
    logic        ovf2;
    logic        busy2;

    int checks_cnt;
    int fail_cnt;

    nibble_serial_adder #(.NIBBLES(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    nibble_serial_adder #(.NIBBLES(2)) dut2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .a         (a2),
        .b         (b2),
        .cin       (cin2),
        .out_valid (out_valid2),
        .out_ready (out_ready2),
        .sum       (sum2),
        .cout      (cout2),
        .ovf       (ovf2),
        .busy      (busy2)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Wait (bounded) for out_valid on the 4-nibble build; returns edges seen.
    task automatic wait_out4(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
    endtask

    // One full transaction on the 4-nibble build with out_ready held high.
    task automatic run4(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                        input logic tc, input logic [15:0] esum, input logic ecout,
                        input logic eovf);
        int lat;
        @(negedge clk);
        check_val({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a         = ta;
        b         = tb;
        cin       = tc;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check_val({tag, "_busy"}, 32'(busy), 32'd1);
        wait_out4(lat);
        check_val({tag, "_latency"}, 32'(lat), 32'd4);
        check_val({tag, "_sum"}, 32'(sum), 32'(esum));
        check_val({tag, "_cout"}, 32'(cout), 32'(ecout));
        check_val({tag, "_ovf"}, 32'(ovf), 32'(eovf));
        @(posedge clk);
        @(negedge clk);
        check_val({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
        check_val({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        check_val({tag, "_hold_sum"}, 32'(sum), 32'(esum));
    endtask

    initial begin
        int lat;
        checks_cnt = 0;
        fail_cnt   = 0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        a          = 16'h0000;
        b          = 16'h0000;
        cin        = 1'b0;
        out_ready  = 1'b1;
        in_valid2  = 1'b0;
        a2         = 8'h00;
        b2         = 8'h00;
        cin2       = 1'b0;
        out_ready2 = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check_val("rst_sum", 32'(sum), 32'd0);
        check_val("rst_valid", 32'(out_valid), 32'd0);
        check_val("rst_ready", 32'(in_ready), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_cout_ovf", {30'd0, cout, ovf}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_val("post_rst_ready", 32'(in_ready), 32'd1);

        // Basic and carry/overflow patterns
        run4("basic", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
        run4("ripple", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
        run4("posovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        run4("negovf", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);

        // Backpressure: hold result while new operands are offered
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a         = 16'h0F0F;
        b         = 16'h0101;
        cin       = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        wait_out4(lat);
        check_val("bp_latency", 32'(lat), 32'd4);
        in_valid = 1'b1;
        a        = 16'hAAAA;
        b        = 16'h1111;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_val("bp_valid", 32'(out_valid), 32'd1);
            check_val("bp_sum", 32'(sum), 32'h1010);
            check_val("bp_cout", 32'(cout), 32'd0);
            check_val("bp_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_val("bp_release_valid", 32'(out_valid), 32'd0);
        check_val("bp_release_ready", 32'(in_ready), 32'd1);
        check_val("bp_release_sum", 32'(sum), 32'h1010);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check_val("bp_accept_busy", 32'(busy), 32'd1);
        wait_out4(lat);
        check_val("bp2_latency", 32'(lat), 32'd4);
        check_val("bp2_sum", 32'(sum), 32'hBBBB);
        @(posedge clk);
        @(negedge clk);

        // Asynchronous reset two cycles into RUN
        in_valid = 1'b1;
        a        = 16'h1234;
        b        = 16'h4321;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_val("mid_rst_sum", 32'(sum), 32'd0);
        check_val("mid_rst_busy", 32'(busy), 32'd0);
        check_val("mid_rst_ready", 32'(in_ready), 32'd0);
        check_val("mid_rst_valid", 32'(out_valid), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_val("mid_rst_no_valid", 32'(out_valid), 32'd0);
        end
        run4("post_rst", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

        // 2-nibble build
        @(negedge clk);
        check_val("n2_ready", 32'(in_ready2), 32'd1);
        in_valid2 = 1'b1;
        a2        = 8'hF0;
        b2        = 8'h10;
        cin2      = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid2 = 1'b0;
        lat = 0;
        while (!out_valid2 && lat < 20) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        check_val("n2_latency", 32'(lat), 32'd2);
        check_val("n2_sum", 32'(sum2), 32'h00);
        check_val("n2_cout", 32'(cout2), 32'd1);
        check_val("n2_ovf", 32'(ovf2), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check_val("n2_idle", 32'(in_ready2), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule
